// File: rtl/aes_pkg.sv
// Shared AES MixColumns definitions: field polynomial, column width,
// controller state encoding and the xtime primitive used by every lane.
package aes_pkg;

    localparam logic [7:0] AES_POLY = 8'h1B;
    localparam int         COL_W    = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/mixcol_lane.sv
// One-column MixColumns / InvMixColumns datapath (purely combinational).
// The inverse reuses the forward network after a cheap pre-conditioning step.
module mixcol_lane
    import aes_pkg::*;
(
    input  logic [COL_W-1:0] col,
    input  logic             inv,
    output logic [COL_W-1:0] res
);

    logic [7:0] a0, a1, a2, a3;
    logic [7:0] u, v;
    logic [7:0] b0, b1, b2, b3;

    always_comb begin
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        u  = xtime(xtime(a0 ^ a2));
        v  = xtime(xtime(a1 ^ a3));
        // {0E,0B,0D,09} factors as {02,03,01,01} times {05,00,04,00}.
        if (inv) begin
            a0 = a0 ^ u;
            a1 = a1 ^ v;
            a2 = a2 ^ u;
            a3 = a3 ^ v;
        end
        b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        b1 = xtime(a1) ^ xtime(a2) ^ a2 ^ a3 ^ a0;
        b2 = xtime(a2) ^ xtime(a3) ^ a3 ^ a0 ^ a1;
        b3 = xtime(a3) ^ xtime(a0) ^ a0 ^ a1 ^ a2;
        res = {b0, b1, b2, b3};
    end

endmodule

// File: rtl/mixcol_iter.sv
// Iterative AES (Inv)MixColumns: accepts a 128-bit state, transforms
// COLS_PER_CYCLE columns per cycle in place, then holds the result until taken.
module mixcol_iter
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1,
    parameter int OUT_REG        = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
            $error("mixcol_iter: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    state_e       state_q;
    logic [127:0] data_q;
    logic [127:0] data_nxt;
    logic         inv_q;
    logic [1:0]   col_q;
    logic         rdy_q;
    logic         last_grp;

    logic [COL_W-1:0] lane_in  [COLS_PER_CYCLE];
    logic [COL_W-1:0] lane_out [COLS_PER_CYCLE];

    assign last_grp  = (col_q == 2'(4 - COLS_PER_CYCLE));
    assign in_ready  = rdy_q && (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);

    // col_q is always a multiple of COLS_PER_CYCLE, so col_q+k never exceeds 3.
    always_comb begin
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            lane_in[k] = data_q[127 - COL_W * (int'(col_q) + k) -: COL_W];
        end
    end

    always_comb begin
        data_nxt = data_q;
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            data_nxt[127 - COL_W * (int'(col_q) + k) -: COL_W] = lane_out[k];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < COLS_PER_CYCLE; gi++) begin : g_lane
            mixcol_lane u_lane (
                .col (lane_in[gi]),
                .inv (inv_q),
                .res (lane_out[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            inv_q   <= 1'b0;
            col_q   <= 2'd0;
            rdy_q   <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        data_q  <= in_data;
                        inv_q   <= in_inv;
                        col_q   <= 2'd0;
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    data_q <= data_nxt;
                    col_q  <= col_q + 2'(COLS_PER_CYCLE);
                    if (last_grp) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [127:0] out_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    out_q <= '0;
                end else if (state_q == ST_BUSY && last_grp) begin
                    out_q <= data_nxt;
                end
            end
            assign out_data = out_q;
        end else begin : g_out_comb
            // Finished state already sits in data_q once DONE is reached.
            assign out_data = data_q;
        end
    endgenerate

endmodule

// File: doc/mixcol_iter.md
MIXCOL_ITER -- requirements
Module: mixcol_iter

Interface
REQ-001 SHALL have parameter COLS_PER_CYCLE, default 1, columns processed per cycle; legal values 1, 2, 4.
REQ-002 SHALL have parameter OUT_REG, default 1, registered output stage when 1; combinational final column path to out_data when 0.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, in_data/in_inv are valid this cycle.
REQ-006 SHALL have port in_ready, output, 1, block accepts a state this cycle.
REQ-007 SHALL have port in_data, input, 128, AES state; column c at bits [127-32c -: 32], row 0 at the top byte of each column.
REQ-008 SHALL have port in_inv, input, 1, 0 = MixColumns, 1 = InvMixColumns.
REQ-009 SHALL have port out_valid, output, 1, out_data holds a completed result.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts out_data this cycle.
REQ-011 SHALL have port out_data, output, 128, transformed state, same column/row layout as in_data.
REQ-012 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-014 SHALL assert in_ready only in IDLE; an accept occurs when in_valid && in_ready. On accept: latch in_data and in_inv, clear column counter, go to BUSY.
REQ-015 In BUSY, SHALL transform COLS_PER_CYCLE columns per cycle, lowest column index first, writing results back into the state register; the mode latched at accept stays fixed for the whole operation.
REQ-016 Column counter SHALL be 2 bits, advance by COLS_PER_CYCLE, and wrap to 0 on the final group. On the final group, the FSM SHALL move to DONE.
REQ-017 Latency SHALL be 4/COLS_PER_CYCLE BUSY cycles from the accept edge to out_valid=1 (4, 2 or 1 cycles).
REQ-018 In DONE, out_valid SHALL be 1 and out_data SHALL hold stable while out_ready=0.
REQ-019 When out_valid && out_ready, the block SHALL return to IDLE. No new input is accepted in that same cycle; in_ready rises the following cycle.
REQ-020 Forward column: with input bytes a0..a3, b_i = 2*a_i ^ 3*a_(i+1) ^ a_(i+2) ^ a_(i+3) over GF(2^8); xtime reduction polynomial 0x11B.
REQ-021 Inverse column: compute u = xtime(xtime(a0^a2)) and v = xtime(xtime(a1^a3)); set a0^=u, a1^=v, a2^=u, a3^=v; then apply the forward transform. This equals multiplication by the {0E,0B,0D,09} matrix.
REQ-022 in_valid asserted while not IDLE SHALL be ignored; in_data and in_inv SHALL not be sampled.
REQ-023 Illegal COLS_PER_CYCLE SHALL trigger an elaboration-time error.

Reset
REQ-024 rst=1 SHALL asynchronously force: FSM to IDLE; state register, mode and counter to 0; out_valid=0; busy=0; out_data=0.
REQ-025 in_ready SHALL be 0 while rst=1 and 1 from the first clock edge after rst is deasserted.
REQ-026 rst asserted mid-BUSY or in DONE SHALL abort the operation with no output. A held result SHALL be discarded.

Structure
REQ-027 Package aes_pkg SHALL hold: the AES_POLY constant (8'h1B); the FSM state enum type; the column-slice width constant (32).
REQ-028 SHALL instantiate sub-module mixcol_lane (32-bit column in, inv, 32-bit out; combinational) COLS_PER_CYCLE times. Each lane SHALL reuse the existing xtime primitive.

Verification
REQ-029 Forward mode, COLS_PER_CYCLE=1, columns db135345 / f20a225c / c6c6c6c6 / 01010101 -> 8e4da1bc / 9fdc589d / c6c6c6c6 / 01010101; out_valid 4 cycles after accept.
REQ-030 Forward mode, COLS_PER_CYCLE=4, state d4bf5d30e0b452aeb84111f11e2798e5 -> 046681e5e0cb199a48f8d37a2806264c; latency 1 cycle.
REQ-031 Inverse mode, all parameter values, input 046681e5e0cb199a48f8d37a2806264c -> d4bf5d30e0b452aeb84111f11e2798e5; random round-trip of forward then inverse returns the original state.
REQ-032 Backpressure: out_ready held 0 for 5 cycles in DONE -> out_data stable and in_ready=0 throughout; second in_valid in that window ignored.
REQ-033 Reset mid-operation: rst pulsed at BUSY cycle 2 of 4 -> all outputs 0 immediately, no out_valid; next accept completes correctly.
REQ-034 Back-to-back stream: in_valid and out_ready tied high, COLS_PER_CYCLE=2 -> one result per 4 cycles (accept, 2 BUSY, DONE handoff), results in order.
